// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// waits on ihit/dhit with a per-request timeout, and counts retired instructions.
module multicycle_control_unit #(
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  output logic [WORD_W-1:0] ir,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWr,
  output logic              MemToReg,
  output logic [3:0]        alu_op,
  output logic [1:0]        ALUsrc,
  output logic [1:0]        RegDst,
  output logic [1:0]        JumpSel,
  output logic              ExtOp,
  output logic              halt,
  output logic              mem_err,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  instr_cnt
);

  // ALU operation codes (aluop_t ordering)
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR  = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                         F_SLTU = 6'h2B;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_HALT
  } cls_t;

  state_t            state, next_state;
  cls_t              cls;
  logic [3:0]        dec_alu;
  logic [1:0]        dec_src, dec_dst;
  logic              dec_ext;
  logic [WAIT_W-1:0] wait_cnt;
  logic              post_rst, retire, timeout, hit_fetch, wait_last;
  logic [5:0]        opcode, funct;

  assign opcode  = ir[WORD_W-1 -: 6];
  assign funct   = ir[5:0];
  assign state_o = state;

  always_comb begin
    cls     = C_NONE;
    dec_alu = ALU_SLL;
    dec_src = 2'b00;
    dec_ext = 1'b0;
    dec_dst = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        cls     = C_RALU;
        dec_dst = 2'b01;
        case (funct)
          F_SLL:          begin dec_alu = ALU_SLL; dec_src = 2'b10; end
          F_SRL:          begin dec_alu = ALU_SRL; dec_src = 2'b10; end
          F_ADD, F_ADDU:  dec_alu = ALU_ADD;
          F_SUB, F_SUBU:  dec_alu = ALU_SUB;
          F_AND:          dec_alu = ALU_AND;
          F_OR:           dec_alu = ALU_OR;
          F_XOR:          dec_alu = ALU_XOR;
          F_NOR:          dec_alu = ALU_NOR;
          F_SLT:          dec_alu = ALU_SLT;
          F_SLTU:         dec_alu = ALU_SLTU;
          F_JR:           begin cls = C_JR; dec_dst = 2'b00; end
          default:        begin cls = C_NONE; dec_dst = 2'b00; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin cls = C_IALU; dec_alu = ALU_ADD;  dec_src = 2'b01; dec_ext = 1'b1; end
      OP_SLTI:  begin cls = C_IALU; dec_alu = ALU_SLT;  dec_src = 2'b01; dec_ext = 1'b1; end
      OP_SLTIU: begin cls = C_IALU; dec_alu = ALU_SLTU; dec_src = 2'b01; dec_ext = 1'b1; end
      OP_ANDI:  begin cls = C_IALU; dec_alu = ALU_AND;  dec_src = 2'b01; end
      OP_ORI:   begin cls = C_IALU; dec_alu = ALU_OR;   dec_src = 2'b01; end
      OP_XORI:  begin cls = C_IALU; dec_alu = ALU_XOR;  dec_src = 2'b01; end
      OP_LW:    begin cls = C_LW;   dec_alu = ALU_ADD;  dec_src = 2'b01; dec_ext = 1'b1; end
      OP_SW:    begin cls = C_SW;   dec_alu = ALU_ADD;  dec_src = 2'b01; dec_ext = 1'b1; end
      OP_BEQ:   begin cls = C_BEQ;  dec_alu = ALU_SUB; end
      OP_BNE:   begin cls = C_BNE;  dec_alu = ALU_SUB; end
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      OP_HALT:  cls = C_HALT;
      default:  cls = C_NONE;
    endcase
  end

  // Requests: iREN/dREN/dWEN stay high until the matching hit; the transfer
  // completes in the cycle the hit is seen. An ihit in the first cycle after
  // reset belongs to a request dropped by that reset and is ignored.
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWr      = 1'b0;
    MemToReg   = 1'b0;
    alu_op     = ALU_SLL;
    ALUsrc     = 2'b00;
    RegDst     = 2'b00;
    JumpSel    = 2'b00;
    ExtOp      = 1'b0;
    halt       = 1'b0;
    retire     = 1'b0;
    timeout    = 1'b0;
    hit_fetch  = ihit & ~post_rst;
    wait_last  = (TIMEOUT > 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    case (state)
      FETCH: begin
        iREN = 1'b1;
        if (hit_fetch) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end else if (wait_last) begin
          timeout    = 1'b1;
          next_state = HALT;
        end
      end
      DECODE: begin
        if (cls == C_HALT) begin
          retire     = 1'b1;
          next_state = HALT;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        alu_op     = dec_alu;
        ALUsrc     = dec_src;
        ExtOp      = dec_ext;
        RegDst     = dec_dst;
        next_state = FETCH;
        retire     = 1'b1;
        case (cls)
          C_RALU, C_IALU: begin next_state = WB;  retire = 1'b0; end
          C_LW, C_SW:     begin next_state = MEM; retire = 1'b0; end
          C_J:   begin PCWrite = 1'b1; JumpSel = 2'b01; end
          C_JAL: begin PCWrite = 1'b1; JumpSel = 2'b01; RegWr = 1'b1; RegDst = 2'b10; end
          C_JR:  begin PCWrite = 1'b1; JumpSel = 2'b10; end
          C_BEQ: begin PCWrite = zero;  JumpSel = 2'b11; end
          C_BNE: begin PCWrite = ~zero; JumpSel = 2'b11; end
          default: ;
        endcase
      end
      MEM: begin
        dREN = (cls == C_LW);
        dWEN = (cls == C_SW);
        if (dhit) begin
          if (cls == C_LW) begin
            next_state = WB;
          end else begin
            next_state = FETCH;
            retire     = 1'b1;
          end
        end else if (wait_last) begin
          timeout    = 1'b1;
          next_state = HALT;
        end
      end
      WB: begin
        RegWr      = 1'b1;
        MemToReg   = (cls == C_LW);
        RegDst     = (cls == C_RALU) ? 2'b01 : 2'b00;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    halt = 1'b1;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= FETCH;
      ir        <= '0;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      mem_err   <= 1'b0;
      post_rst  <= 1'b1;
    end else begin
      state    <= next_state;
      post_rst <= 1'b0;
      if (IRWrite) ir <= instr;
      if (retire)  instr_cnt <= instr_cnt + 1'b1;
      if (timeout) mem_err <= 1'b1;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if ((state == FETCH || state == MEM) && (TIMEOUT > 0)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle trace, which the player checks.
module tb_multicycle_control_unit;

  localparam int TO = 8;

  localparam int K_NONE = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_BNE = 6,
                 K_J = 7, K_JAL = 8, K_JR = 9, K_HALT = 10;
  localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3, A_AND = 4'd4,
                         A_OR = 4'd5, A_XOR = 4'd6, A_NOR = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_HALT = 3'd5;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instr = '0;
  logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic [31:0] ir, instr_cnt;
  logic        iREN, dREN, dWEN, IRWrite, PCWrite, RegWr, MemToReg, ExtOp, halt, mem_err;
  logic [3:0]  alu_op;
  logic [1:0]  ALUsrc, RegDst, JumpSel;
  logic [2:0]  state_o;
  logic [19:0] dut_ctrl;

  multicycle_control_unit #(.WORD_W(32), .CNT_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
    .ir(ir), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWr(RegWr), .MemToReg(MemToReg), .alu_op(alu_op), .ALUsrc(ALUsrc), .RegDst(RegDst),
    .JumpSel(JumpSel), .ExtOp(ExtOp), .halt(halt), .mem_err(mem_err), .state_o(state_o),
    .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  assign dut_ctrl = {iREN, dREN, dWEN, IRWrite, PCWrite, RegWr, MemToReg, ExtOp, halt, mem_err,
                     ALUsrc, RegDst, JumpSel, alu_op};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_cnt, m_ir;
  int          m_fwait;
  logic [23:0] exp_q[$];   // {state, retire, ctrl}
  logic [34:0] stim_q[$];  // {instr, ihit, dhit, zero}

  logic [5:0] op_tab [0:17] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h10, 6'h3E};
  logic [5:0] fn_tab [0:14] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [19:0] pk(input bit iren, input bit dren, input bit dwen,
      input bit irw, input bit pcw, input bit rw, input bit m2r, input bit ext, input bit hlt,
      input bit merr, input logic [1:0] src, input logic [1:0] dst, input logic [1:0] js,
      input logic [3:0] op);
    return {iren, dren, dwen, irw, pcw, rw, m2r, ext, hlt, merr, src, dst, js, op};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op_tab[$urandom_range(0, 17)];
    if (w[31:26] == 6'h00) w[5:0] = fn_tab[$urandom_range(0, 14)];
    return w;
  endfunction

  task automatic model_decode(input logic [31:0] w, output int kind, output logic [3:0] aop,
                              output logic [1:0] src, output bit ext);
    kind = K_NONE; aop = A_SLL; src = 2'd0; ext = 1'b0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00:        begin kind = K_R; aop = A_SLL; src = 2'd2; end
        6'h02:        begin kind = K_R; aop = A_SRL; src = 2'd2; end
        6'h08:        kind = K_JR;
        6'h20, 6'h21: begin kind = K_R; aop = A_ADD; end
        6'h22, 6'h23: begin kind = K_R; aop = A_SUB; end
        6'h24:        begin kind = K_R; aop = A_AND; end
        6'h25:        begin kind = K_R; aop = A_OR; end
        6'h26:        begin kind = K_R; aop = A_XOR; end
        6'h27:        begin kind = K_R; aop = A_NOR; end
        6'h2A:        begin kind = K_R; aop = A_SLT; end
        6'h2B:        begin kind = K_R; aop = A_SLTU; end
        default: ;
      endcase
      6'h08, 6'h09: begin kind = K_I; aop = A_ADD;  src = 2'd1; ext = 1'b1; end
      6'h0A:        begin kind = K_I; aop = A_SLT;  src = 2'd1; ext = 1'b1; end
      6'h0B:        begin kind = K_I; aop = A_SLTU; src = 2'd1; ext = 1'b1; end
      6'h0C:        begin kind = K_I; aop = A_AND;  src = 2'd1; end
      6'h0D:        begin kind = K_I; aop = A_OR;   src = 2'd1; end
      6'h0E:        begin kind = K_I; aop = A_XOR;  src = 2'd1; end
      6'h23:        begin kind = K_LW; aop = A_ADD; src = 2'd1; ext = 1'b1; end
      6'h2B:        begin kind = K_SW; aop = A_ADD; src = 2'd1; ext = 1'b1; end
      6'h04:        begin kind = K_BEQ; aop = A_SUB; end
      6'h05:        begin kind = K_BNE; aop = A_SUB; end
      6'h02:        kind = K_J;
      6'h03:        kind = K_JAL;
      6'h3F:        kind = K_HALT;
      default: ;
    endcase
  endtask

  task automatic push(input logic [2:0] st, input bit ret, input logic [19:0] c,
                      input bit ih, input bit dh, input bit z, input logic [31:0] w);
    exp_q.push_back({st, ret, c});
    stim_q.push_back({w, ih, dh, z});
  endtask

  task automatic gen_halt(input int n, input bit merr);
    for (int i = 0; i < n; i++)
      push(S_HALT, 1'b0, pk(0,0,0,0,0,0,0,0,1,merr,2'd0,2'd0,2'd0,4'd0), rb(), rb(), rb(), $urandom);
  endtask

  // Expected trace of one instruction: ih missed fetch cycles, dh missed memory
  // cycles (dh >= TO means the data request never completes).
  task automatic gen(input logic [31:0] w, input int ih_in, input int dh, input bit z);
    int kind, ih;
    logic [3:0] aop;
    logic [1:0] src, edst, js;
    bit ext, pcw, rw, fin, is_lw;
    model_decode(w, kind, aop, src, ext);
    ih = ih_in;
    if (ih > TO - 1 - m_fwait) ih = TO - 1 - m_fwait;
    m_fwait = 0;
    for (int i = 0; i < ih; i++)
      push(S_FETCH, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), 1'b0, rb(), z, w);
    push(S_FETCH, 1'b0, pk(1,0,0,1,1,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), 1'b1, rb(), z, w);
    push(S_DECODE, kind == K_HALT, 20'd0, rb(), rb(), z, $urandom);
    if (kind == K_HALT) begin
      gen_halt(20, 1'b0);
      return;
    end
    pcw = 1'b0; rw = 1'b0; js = 2'b00;
    edst = (kind == K_R) ? 2'b01 : 2'b00;
    case (kind)
      K_J:   begin pcw = 1'b1; js = 2'b01; end
      K_JAL: begin pcw = 1'b1; js = 2'b01; rw = 1'b1; edst = 2'b10; end
      K_JR:  begin pcw = 1'b1; js = 2'b10; end
      K_BEQ: begin pcw = z;  js = 2'b11; end
      K_BNE: begin pcw = !z; js = 2'b11; end
      default: ;
    endcase
    fin = !(kind == K_R || kind == K_I || kind == K_LW || kind == K_SW);
    push(S_EXEC, fin, pk(0,0,0,0,pcw,rw,0,ext,0,0,src,edst,js,aop), rb(), rb(), z, $urandom);
    if (kind == K_R || kind == K_I)
      push(S_WB, 1'b1, pk(0,0,0,0,0,1,0,0,0,0,2'd0,edst,2'd0,4'd0), rb(), rb(), z, $urandom);
    if (kind == K_LW || kind == K_SW) begin
      is_lw = (kind == K_LW);
      if (dh >= TO) begin
        for (int i = 0; i < TO; i++)
          push(S_MEM, 1'b0, pk(0,is_lw,!is_lw,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), rb(), 1'b0, z, $urandom);
        gen_halt(5, 1'b1);
        return;
      end
      for (int i = 0; i < dh; i++)
        push(S_MEM, 1'b0, pk(0,is_lw,!is_lw,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), rb(), 1'b0, z, $urandom);
      push(S_MEM, !is_lw, pk(0,is_lw,!is_lw,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), rb(), 1'b1, z, $urandom);
      if (is_lw)
        push(S_WB, 1'b1, pk(0,0,0,0,0,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0), rb(), rb(), z, $urandom);
    end
  endtask

  task automatic play_n(input int k);
    logic [23:0] e;
    logic [34:0] s;
    for (int i = 0; i < k && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      instr = s[34:3]; ihit = s[2]; dhit = s[1]; zero = s[0];
      @(negedge CLK);
      check("state", {29'd0, state_o}, {29'd0, e[23:21]});
      check("ctrl", {12'd0, dut_ctrl}, {12'd0, e[19:0]});
      check("instr_cnt", instr_cnt, m_cnt);
      check("ir", ir, m_ir);
      @(posedge CLK);
      #1;
      if (e[20]) m_cnt++;
      if (e[16]) m_ir = s[34:3];
    end
  endtask

  task automatic play();
    play_n(1 << 30);
  endtask

  // One reset cycle, then the first FETCH cycle with ihit raised must be ignored.
  task automatic do_reset();
    exp_q.delete();
    stim_q.delete();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    m_cnt = '0; m_ir = '0; m_fwait = 0;
    push(S_FETCH, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), 1'b1, rb(), rb(), $urandom);
    play();
    m_fwait = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    gen(32'h20010005, 0, 0, 1'b0); play();         // ADDI, hit on 2nd FETCH cycle
    gen(32'h8C220004, 0, 3, 1'b0); play();         // LW, dhit 3 cycles late
    gen(32'h10220003, 0, 0, 1'b1); play();         // BEQ taken
    gen(32'h10220003, 0, 0, 1'b0); play();         // BEQ not taken
    gen(32'h00221820, 7, 0, 1'b0); play();         // ADD, ihit on last allowed cycle
    gen(32'hAC220008, 2, 7, 1'b0); play();         // SW, dhit on last allowed cycle
    gen(32'h0C000010, 1, 0, 1'b0); play();         // JAL
    gen(32'h03E00008, 0, 0, 1'b0); play();         // JR
    for (int i = 0; i < 60; i++) begin
      gen(rand_word(), $urandom_range(0, 7), $urandom_range(0, 7), rb());
      play();
    end
    gen(32'hFC000000, 1, 0, 1'b0); play();         // HALT, then 20 cycles of noise

    do_reset();
    gen(32'hAC220008, 0, 5, 1'b0); play_n(4);      // stop inside MEM with dWEN high
    do_reset();                                    // reset check: FETCH, dWEN=0, cnt=0

    for (int i = 0; i < TO - 1; i++)               // fetch timeout
      push(S_FETCH, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0), 1'b0, rb(), rb(), $urandom);
    gen_halt(5, 1'b1);
    play();

    do_reset();
    gen(32'h8C220004, 0, TO, 1'b0); play();        // data timeout, no retire

    do_reset();
    gen(32'h08000004, 0, 0, 1'b0); play();         // J after recovery
    gen(32'h14220003, 0, 0, 1'b0); play();         // BNE taken

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
